// File: rtl/alu_rr_scheduler_if.sv
// Request, ALU and response bundle for alu_rr_scheduler.
// The slave modport is the scheduler's view. The master modport is the view of the requesters, the ALU and the response sink.
interface alu_rr_scheduler_if #(
    parameter int DATA_W  = 128,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*4-1:0]      req_opcode;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;

    logic [3:0]                alu_opcode;
    logic [DATA_W-1:0]         alu_input1;
    logic [DATA_W-1:0]         alu_input2;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_carry;
    logic                      alu_zero;
    logic                      alu_ovf;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_carry;
    logic                      rsp_zero;
    logic                      rsp_ovf;
    logic                      rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b,
        input  alu_result, alu_carry, alu_zero, alu_ovf,
        input  rsp_ready,
        output req_ready,
        output alu_opcode, alu_input1, alu_input2,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b,
        output alu_result, alu_carry, alu_zero, alu_ovf,
        output rsp_ready,
        input  req_ready,
        input  alu_opcode, alu_input1, alu_input2,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one combinational ALU among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_SCHED_OPCHECK_EN: opcodes > 4 are accepted but not issued, and they are answered at once with rsp_err=1.
module alu_rr_scheduler #(
    parameter int DATA_W  = 128,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_rr_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_gnt_vld;
    logic              w_accept;
    logic              w_op_illegal;
    logic [3:0]        w_gnt_op;
    logic [DATA_W-1:0] w_gnt_a;
    logic [DATA_W-1:0] w_gnt_b;

    logic [3:0]        r_alu_opcode;
    logic [DATA_W-1:0] r_alu_input1;
    logic [DATA_W-1:0] r_alu_input2;
    logic [ID_W-1:0]   r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_carry;
    logic              r_rsp_zero;
    logic              r_rsp_ovf;
    logic              r_rsp_err;

    // Walk the offsets from farthest to nearest so that the first valid index at or after r_rr_ptr is written last.
    always_comb begin
        int cand;
        cand      = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (bus.req_valid[cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = ID_W'(cand);
            end
        end
    end

    assign w_gnt_op = bus.req_opcode[int'(w_gnt_idx)*4 +: 4];
    assign w_gnt_a  = bus.req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_gnt_b  = bus.req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_accept = (r_state == S_IDLE) && w_gnt_vld;

`ifdef ALU_SCHED_OPCHECK_EN
    assign w_op_illegal = (w_gnt_op > 4'd4);
`else
    assign w_op_illegal = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_state_nxt = w_op_illegal ? S_RESP : S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_accept) bus.req_ready[w_gnt_idx] = 1'b1;
        bus.rsp_valid = (r_state == S_RESP);
    end

    // NOTE: the datapath registers are reset explicitly, because every alu_*/rsp_* output must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rsp_id <= w_gnt_idx;
                        if (w_op_illegal) begin
                            r_rsp_result <= '0;
                            r_rsp_carry  <= 1'b0;
                            r_rsp_zero   <= 1'b0;
                            r_rsp_ovf    <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end else begin
                            r_alu_opcode <= w_gnt_op;
                            r_alu_input1 <= w_gnt_a;
                            r_alu_input2 <= w_gnt_b;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_carry  <= bus.alu_carry;
                    r_rsp_zero   <= bus.alu_zero;
                    r_rsp_ovf    <= bus.alu_ovf;
                    r_rsp_err    <= 1'b0;
                end
                S_RESP: begin
                    if (bus.rsp_ready)
                        r_rr_ptr <= (r_rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : r_rsp_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_input1 = r_alu_input1;
    assign bus.alu_input2 = r_alu_input2;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_ovf    = r_rsp_ovf;
    assign bus.rsp_err    = r_rsp_err;
endmodule
